ysyx_2022040010_lsu_stage: RTL and testbench

Parametrised successor to the memory stage. It sits between EX and WB and replaces the zero-latency load path with a valid/ready request/response interface to a variable-latency data memory. It performs load extract/extend at any byte offset and store lane shifting with a byte strobe. It flags misaligned accesses and back-pressures EX while a memory access is outstanding. Its registered result also drives the regfile bypass bus.

---
 rtl/ysyx_2022040010_lsu_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_ysyx_2022040010_lsu_stage.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_lsu_stage.sv
// Load/store stage between EX and WB with a valid/ready data-memory port.
// One memory access in flight; result register doubles as the bypass source.
module ysyx_2022040010_lsu_stage #(
    parameter int XLEN = 64,
    parameter int NB   = XLEN / 8,
    parameter int OFFW = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_ex_result,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic            in_rf_we,
    input  logic [4:0]      in_rf_waddr,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [NB-1:0]   dmem_req_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            out_rf_we,
    output logic [4:0]      out_rf_waddr,
    output logic [XLEN-1:0] out_rf_wdata,
    output logic            out_misalign,
    output logic            bp_rf_we,
    output logic [4:0]      bp_rf_waddr,
    output logic [XLEN-1:0] bp_rf_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT
    } state_e;

    state_e          state_q, state_d;
    logic            req_we_q, req_we_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [NB-1:0]   req_wstrb_q, req_wstrb_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_rf_we_q, out_rf_we_d;
    logic [4:0]      out_rf_waddr_q, out_rf_waddr_d;
    logic [XLEN-1:0] out_rf_wdata_q, out_rf_wdata_d;
    logic            out_misalign_q, out_misalign_d;

    logic            accept;
    logic            in_mem;
    logic            in_mis;
    logic [OFFW-1:0] in_off;
    logic [7:0]      base_strb;
    logic [2*NB-1:0] strb_wide;
    logic [XLEN-1:0] ld_sh;
    logic [XLEN-1:0] ld_mask;
    logic            ld_sign;
    logic [XLEN-1:0] ld_val;

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
    assign accept   = in_valid & in_ready;
    assign in_mem   = in_is_load | in_is_store;
    assign in_off   = in_addr[OFFW-1:0];

    always_comb begin
        in_mis = 1'b0;
        base_strb = 8'h01;
        unique case (in_size)
            2'd0: begin
                in_mis = 1'b0;
                base_strb = 8'h01;
            end
            2'd1: begin
                in_mis = in_addr[0];
                base_strb = 8'h03;
            end
            2'd2: begin
                in_mis = |in_addr[1:0];
                base_strb = 8'h0f;
            end
            default: begin
                // Doubleword accesses do not exist on a 32-bit datapath.
                in_mis = (XLEN == 32) || (|in_addr[2:0]);
                base_strb = 8'hff;
            end
        endcase
        strb_wide = (2*NB)'(base_strb) << in_off;
    end

    always_comb begin
        ld_sh = dmem_rsp_rdata >> {off_q, 3'b000};
        ld_mask = '1;
        ld_sign = 1'b0;
        unique case (size_q)
            2'd0: begin
                ld_mask = XLEN'(8'hff);
                ld_sign = ld_sh[7];
            end
            2'd1: begin
                ld_mask = XLEN'(16'hffff);
                ld_sign = ld_sh[15];
            end
            2'd2: begin
                ld_mask = XLEN'(32'hffff_ffff);
                ld_sign = ld_sh[31];
            end
            default: begin
                ld_mask = '1;
                ld_sign = 1'b0;
            end
        endcase
        ld_val = (ld_sh & ld_mask) | ({XLEN{ld_sign & ~uns_q}} & ~ld_mask);
    end

    always_comb begin
        state_d        = state_q;
        req_we_d       = req_we_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        req_wstrb_d    = req_wstrb_q;
        off_d          = off_q;
        size_d         = size_q;
        uns_d          = uns_q;
        out_pc_d       = out_pc_q;
        out_rf_we_d    = out_rf_we_q;
        out_rf_waddr_d = out_rf_waddr_q;
        out_rf_wdata_d = out_rf_wdata_q;
        out_misalign_d = out_misalign_q;

        case (state_q)
            S_REQ: begin
                if (dmem_req_ready) begin
                    state_d = req_we_q ? S_OUT : S_RESP;
                end
            end
            S_RESP: begin
                if (dmem_rsp_valid) begin
                    out_rf_wdata_d = ld_val;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // A new op may land while the previous result is leaving OUT.
        if (accept) begin
            out_pc_d       = in_pc;
            out_rf_waddr_d = in_rf_waddr;
            out_rf_wdata_d = in_ex_result;
            out_misalign_d = in_mem & in_mis;
            out_rf_we_d    = in_rf_we & (in_rf_waddr != 5'd0)
                           & ~(in_mem & in_mis) & ~in_is_store;
            if (in_mem & ~in_mis) begin
                state_d     = S_REQ;
                req_we_d    = in_is_store;
                req_addr_d  = {in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                req_wdata_d = in_wdata << {in_off, 3'b000};
                req_wstrb_d = in_is_store ? strb_wide[NB-1:0] : '0;
                off_d       = in_off;
                size_d      = in_size;
                uns_d       = in_unsigned;
            end else begin
                state_d = S_OUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            req_we_q       <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_wstrb_q    <= '0;
            off_q          <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            out_pc_q       <= '0;
            out_rf_we_q    <= 1'b0;
            out_rf_waddr_q <= '0;
            out_rf_wdata_q <= '0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_we_q       <= req_we_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            req_wstrb_q    <= req_wstrb_d;
            off_q          <= off_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            out_pc_q       <= out_pc_d;
            out_rf_we_q    <= out_rf_we_d;
            out_rf_waddr_q <= out_rf_waddr_d;
            out_rf_wdata_q <= out_rf_wdata_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_req_we    = req_we_q;
    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_wdata = req_wdata_q;
    assign dmem_req_wstrb = req_wstrb_q;

    assign out_valid    = (state_q == S_OUT);
    assign out_pc       = out_pc_q;
    assign out_rf_we    = out_rf_we_q;
    assign out_rf_waddr = out_rf_waddr_q;
    assign out_rf_wdata = out_rf_wdata_q;
    assign out_misalign = out_misalign_q;

    assign bp_rf_we    = out_valid & out_rf_we_q;
    assign bp_rf_waddr = out_rf_waddr_q;
    assign bp_rf_wdata = out_rf_wdata_q;

endmodule

// File: tb/tb_ysyx_2022040010_lsu_stage.sv
// Bench for the LSU stage: directed scenarios, then random ops checked
// against a byte-addressed memory model and an in-order expectation queue.
module tb_ysyx_2022040010_lsu_stage;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_addr, in_ex_result, in_wdata;
    logic        in_is_load, in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned, in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [63:0] dmem_req_addr, dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rsp_rdata;
    logic        out_valid, out_ready;
    logic [63:0] out_pc;
    logic        out_rf_we;
    logic [4:0]  out_rf_waddr;
    logic [63:0] out_rf_wdata;
    logic        out_misalign;
    logic        bp_rf_we;
    logic [4:0]  bp_rf_waddr;
    logic [63:0] bp_rf_wdata;

    ysyx_2022040010_lsu_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_addr(in_addr),
        .in_ex_result(in_ex_result), .in_wdata(in_wdata),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rf_we(out_rf_we),
        .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .out_misalign(out_misalign),
        .bp_rf_we(bp_rf_we), .bp_rf_waddr(bp_rf_waddr),
        .bp_rf_wdata(bp_rf_wdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] pc, addr, ex, wd,
                          input logic ld, st, input logic [1:0] sz,
                          input logic un, we, input logic [4:0] wa);
        in_pc = pc; in_addr = addr; in_ex_result = ex; in_wdata = wd;
        in_is_load = ld; in_is_store = st; in_size = sz;
        in_unsigned = un; in_rf_we = we; in_rf_waddr = wa;
        in_valid = 1'b1;
    endtask

    task automatic lb_case(input logic un, input logic [63:0] exp);
        set_op(64'h200, 64'h8000_0003, 64'h8000_0003, 64'h0,
               1'b1, 1'b0, 2'd0, un, 1'b1, 5'd7);
        dmem_req_ready = 1'b1;
        nxt(); in_valid = 1'b0; #1;
        check("lb_req_valid", 64'(dmem_req_valid), 64'd1);
        check("lb_req_addr", dmem_req_addr, 64'h8000_0000);
        check("lb_req_wstrb", 64'(dmem_req_wstrb), 64'd0);
        check("lb_req_we", 64'(dmem_req_we), 64'd0);
        nxt();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 64'h0000_0000_80FF_0000;
        #1;
        check("lb_resp_no_out", 64'(out_valid), 64'd0);
        nxt(); dmem_rsp_valid = 1'b0; #1;
        check("lb_out_valid", 64'(out_valid), 64'd1);
        check("lb_data", out_rf_wdata, exp);
        check("lb_rf_we", 64'(out_rf_we), 64'd1);
        out_ready = 1'b1;
        nxt(); out_ready = 1'b0; dmem_req_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        chkd;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wd;
        logic [7:0]  st;
    } req_t;

    exp_t        eq[$];
    req_t        rq[$];
    logic [7:0]  refmem[128];
    logic [7:0]  dmem_b[128];
    bit          have_op = 0;
    int          rsp_cnt = -1;
    logic [63:0] rsp_word;
    bit          out_hold = 0, req_hold = 0;
    logic [63:0] h_pc, h_wd, h_raddr, h_rwd;
    logic [4:0]  h_wa;
    logic [7:0]  h_st;
    logic        h_we, h_mis, h_rwe;

    task automatic gen_op();
        int kind;
        kind = $urandom_range(0, 2);
        in_is_load  = (kind == 1);
        in_is_store = (kind == 2);
        in_size     = 2'($urandom_range(0, 3));
        in_addr     = BASE + 64'($urandom_range(0, 63));
        in_ex_result = (kind == 0) ? {$urandom, $urandom} : in_addr;
        in_wdata    = {$urandom, $urandom};
        in_pc       = {32'h0, $urandom};
        in_unsigned = 1'($urandom_range(0, 1));
        in_rf_we    = 1'($urandom_range(0, 1));
        in_rf_waddr = 5'($urandom_range(0, 31));
    endtask

    // Reference semantics of an accepted op, in spec terms.
    task automatic model();
        exp_t e;
        req_t r;
        bit mem, mis;
        int n, off, idx;
        logic [63:0] v;
        mem = in_is_load | in_is_store;
        n = 1 << in_size;
        mis = mem && ((in_addr % 64'(n)) != 0);
        e.pc = in_pc; e.wa = in_rf_waddr; e.mis = mis;
        e.we = in_rf_we && (in_rf_waddr != 0) && !mis && !in_is_store;
        e.chkd = !in_is_store && !mis;
        e.wd = in_ex_result;
        if (mem && !mis) begin
            off = int'(in_addr % 8);
            idx = int'(in_addr - BASE);
            r.addr = in_addr - 64'(off);
            r.we = in_is_store;
            r.wd = in_wdata << (8 * off);
            r.st = 8'h0;
            if (in_is_store) begin
                for (int i = 0; i < n; i++) begin
                    r.st[off + i] = 1'b1;
                    refmem[idx + i] = in_wdata[8*i +: 8];
                end
            end else begin
                v = 64'h0;
                for (int i = 0; i < n; i++)
                    v = v | (64'(refmem[idx + i]) << (8 * i));
                if (!in_unsigned && n < 8 && v[8*n-1])
                    v = v | (~64'h0 << (8 * n));
                e.wd = v;
            end
            rq.push_back(r);
        end
        eq.push_back(e);
    endtask

    task automatic rnd_cycle(input bit gen);
        exp_t e;
        req_t r;
        int idx;
        nxt();
        if (rsp_cnt == 0) begin
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = rsp_word;
            rsp_cnt = -1;
        end else begin
            dmem_rsp_valid = 1'b0;
            if (rsp_cnt > 0) rsp_cnt--;
        end
        dmem_req_ready = ($urandom_range(0, 2) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if (!have_op && gen && $urandom_range(0, 3) != 0) begin
            gen_op();
            have_op = 1;
        end
        in_valid = have_op;
        #1;
        if (out_hold) begin
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_pc", out_pc, h_pc);
            check("hold_wdata", out_rf_wdata, h_wd);
            check("hold_flags", {out_rf_we, out_misalign, out_rf_waddr},
                  {h_we, h_mis, h_wa});
        end
        if (req_hold) begin
            check("hold_req_valid", 64'(dmem_req_valid), 64'd1);
            check("hold_req", {dmem_req_addr, dmem_req_wdata},
                  {h_raddr, h_rwd});
            check("hold_req_ctl", {dmem_req_we, dmem_req_wstrb},
                  {h_rwe, h_st});
        end
        if (out_valid && eq.size() == 0)
            check("rnd_spurious_out", 64'd1, 64'd0);
        else if (out_valid && out_ready) begin
            e = eq.pop_front();
            check("rnd_pc", out_pc, e.pc);
            check("rnd_waddr", 64'(out_rf_waddr), 64'(e.wa));
            check("rnd_misalign", 64'(out_misalign), 64'(e.mis));
            check("rnd_rf_we", 64'(out_rf_we), 64'(e.we));
            check("rnd_bp_we", 64'(bp_rf_we), 64'(e.we));
            check("rnd_bp_waddr", 64'(bp_rf_waddr), 64'(e.wa));
            if (e.chkd) begin
                check("rnd_wdata", out_rf_wdata, e.wd);
                check("rnd_bp_wdata", bp_rf_wdata, e.wd);
            end
        end
        if (dmem_req_valid && dmem_req_ready) begin
            if (rq.size() == 0)
                check("rnd_spurious_req", 64'd1, 64'd0);
            else begin
                r = rq.pop_front();
                check("rnd_req_addr", dmem_req_addr, r.addr);
                check("rnd_req_we", 64'(dmem_req_we), 64'(r.we));
                check("rnd_req_wstrb", 64'(dmem_req_wstrb), 64'(r.st));
                if (r.we) check("rnd_req_wdata", dmem_req_wdata, r.wd);
                idx = int'(dmem_req_addr - BASE) & 120;
                if (dmem_req_we) begin
                    for (int i = 0; i < 8; i++)
                        if (dmem_req_wstrb[i])
                            dmem_b[idx + i] = dmem_req_wdata[8*i +: 8];
                end else begin
                    rsp_word = 64'h0;
                    for (int i = 0; i < 8; i++)
                        rsp_word = rsp_word | (64'(dmem_b[idx + i]) << (8 * i));
                    rsp_cnt = $urandom_range(0, 3);
                end
            end
        end
        if (in_valid && in_ready) begin
            model();
            have_op = 0;
        end
        out_hold = out_valid & ~out_ready;
        h_pc = out_pc; h_wd = out_rf_wdata; h_wa = out_rf_waddr;
        h_we = out_rf_we; h_mis = out_misalign;
        req_hold = dmem_req_valid & ~dmem_req_ready;
        h_raddr = dmem_req_addr; h_rwd = dmem_req_wdata;
        h_rwe = dmem_req_we; h_st = dmem_req_wstrb;
    endtask

    initial begin
        in_valid = 0; in_pc = 0; in_addr = 0; in_ex_result = 0;
        in_wdata = 0; in_is_load = 0; in_is_store = 0; in_size = 0;
        in_unsigned = 0; in_rf_we = 0; in_rf_waddr = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
        out_ready = 0;
        for (int i = 0; i < 128; i++) begin
            refmem[i] = 8'($urandom);
            dmem_b[i] = refmem[i];
        end

        repeat (2) nxt();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
        check("rst_wdata", out_rf_wdata, 64'd0);
        check("rst_pc", out_pc, 64'd0);
        nxt(); rst = 1'b1;

        set_op(64'h100, 64'h0, 64'h1234, 64'h0, 1'b0, 1'b0, 2'd3,
               1'b0, 1'b1, 5'd5);
        #1;
        check("nm_in_ready", 64'(in_ready), 64'd1);
        nxt(); in_valid = 1'b0; #1;
        check("nm_out_valid", 64'(out_valid), 64'd1);
        check("nm_wdata", out_rf_wdata, 64'h1234);
        check("nm_bp_we", 64'(bp_rf_we), 64'd1);
        check("nm_bp_waddr", 64'(bp_rf_waddr), 64'd5);
        check("nm_pc", out_pc, 64'h100);
        out_ready = 1'b1;
        nxt(); out_ready = 1'b0; #1;
        check("nm_idle", 64'(out_valid), 64'd0);

        lb_case(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        lb_case(1'b1, 64'h0000_0000_0000_0080);

        set_op(64'h300, 64'h8000_0006, 64'h8000_0006, 64'hBEEF,
               1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd9);
        dmem_req_ready = 1'b0;
        nxt(); in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("sh_req_valid", 64'(dmem_req_valid), 64'd1);
            check("sh_req_addr", dmem_req_addr, 64'h8000_0000);
            check("sh_req_wdata", dmem_req_wdata, 64'hBEEF_0000_0000_0000);
            check("sh_req_wstrb", 64'(dmem_req_wstrb), 64'hC0);
            check("sh_req_we", 64'(dmem_req_we), 64'd1);
            check("sh_in_ready", 64'(in_ready), 64'd0);
            nxt();
        end
        dmem_req_ready = 1'b1;
        nxt(); dmem_req_ready = 1'b0; #1;
        check("sh_out_valid", 64'(out_valid), 64'd1);
        check("sh_rf_we", 64'(out_rf_we), 64'd0);
        check("sh_misalign", 64'(out_misalign), 64'd0);
        out_ready = 1'b1;
        nxt(); out_ready = 1'b0;

        set_op(64'h400, 64'h8000_0002, 64'h8000_0002, 64'h0,
               1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd3);
        nxt(); in_valid = 1'b0; #1;
        check("mis_req_valid", 64'(dmem_req_valid), 64'd0);
        check("mis_out_valid", 64'(out_valid), 64'd1);
        check("mis_flag", 64'(out_misalign), 64'd1);
        check("mis_rf_we", 64'(out_rf_we), 64'd0);
        out_ready = 1'b1;
        nxt(); out_ready = 1'b0;

        set_op(64'h500, 64'h8000_0008, 64'h8000_0008, 64'h0,
               1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd0);
        dmem_req_ready = 1'b1;
        nxt(); in_valid = 1'b0; #1;
        check("ld0_req_valid", 64'(dmem_req_valid), 64'd1);
        nxt();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 64'h1122_3344_5566_7788;
        nxt(); dmem_rsp_valid = 1'b0; #1;
        check("ld0_out_valid", 64'(out_valid), 64'd1);
        check("ld0_rf_we", 64'(out_rf_we), 64'd0);
        check("ld0_bp_we", 64'(bp_rf_we), 64'd0);
        check("ld0_data", out_rf_wdata, 64'h1122_3344_5566_7788);
        out_ready = 1'b1;
        nxt(); out_ready = 1'b0; dmem_req_ready = 1'b0;

        set_op(64'h600, 64'h0, 64'hAAAA, 64'h0, 1'b0, 1'b0, 2'd0,
               1'b0, 1'b1, 5'd10);
        nxt();
        set_op(64'h604, 64'h0, 64'hBBBB, 64'h0, 1'b0, 1'b0, 2'd0,
               1'b0, 1'b1, 5'd11);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bpr_valid", 64'(out_valid), 64'd1);
            check("bpr_data", out_rf_wdata, 64'hAAAA);
            check("bpr_pc", out_pc, 64'h600);
            check("bpr_in_ready", 64'(in_ready), 64'd0);
            nxt();
        end
        out_ready = 1'b1; #1;
        check("bpr_release_ready", 64'(in_ready), 64'd1);
        nxt(); in_valid = 1'b0; #1;
        check("bpr_b_valid", 64'(out_valid), 64'd1);
        check("bpr_b_data", out_rf_wdata, 64'hBBBB);
        check("bpr_b_pc", out_pc, 64'h604);
        nxt(); out_ready = 1'b0;

        set_op(64'h700, 64'h8000_0010, 64'h8000_0010, 64'h0,
               1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd4);
        dmem_req_ready = 1'b1;
        nxt(); in_valid = 1'b0;
        nxt(); #1;
        check("rm_resp_no_out", 64'(out_valid), 64'd0);
        check("rm_resp_no_req", 64'(dmem_req_valid), 64'd0);
        rst = 1'b0;
        nxt(); rst = 1'b1; dmem_req_ready = 1'b0; #1;
        check("rm_idle_ready", 64'(in_ready), 64'd1);
        check("rm_out_valid", 64'(out_valid), 64'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 64'hDEAD_BEEF_0000_0001;
        nxt(); dmem_rsp_valid = 1'b0; #1;
        check("rm_late_rsp", 64'(out_valid), 64'd0);
        nxt(); #1;
        check("rm_late_rsp2", 64'(out_valid), 64'd0);
        check("rm_late_wdata", out_rf_wdata, 64'd0);

        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 60; c++) rnd_cycle(1'b0);
        check("drain_out_queue", 64'(eq.size()), 64'd0);
        check("drain_req_queue", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
